au_sub_serial: RTL
==================

// Module: au_sub_serial
// PURPOSE
//   Digit-serial binary subtractor with valid/ready handshakes on both sides.
//   Splits WIDTH-bit operands into DIGIT-bit digits and processes one digit per
//   cycle, LSD first, through a DIGIT-bit subtract-with-borrow datapath.
//   Area-lean alternative to the single-cycle parallel-prefix subtractor.
//   Sits between an operand producer and a result consumer in a multi-cycle
//   arithmetic datapath.
// PARAMETERS
//   WIDTH  32  operand/result word length (>= 1)
//   DIGIT   8  bits processed per cycle (1 <= DIGIT <= WIDTH)
//   NDIG   --  localparam = ceil(WIDTH/DIGIT), digits per operation
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      operands a/b valid
//   in_ready   out  1      block can accept operands
//   a          in   WIDTH  minuend (unsigned)
//   b          in   WIDTH  subtrahend (unsigned)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   s          out  WIDTH  difference, (a - b) mod 2^WIDTH
//   borrow     out  1      final borrow; 1 iff a < b (unsigned)
//   busy       out  1      high in CALC or DONE
// BEHAVIOUR
//   - Reset (async, rst=1): state=IDLE, out_valid=0, s=0, borrow=0, busy=0,
//     in_ready=1. Reset mid-operation abandons the operation; no result is emitted.
//   - FSM states:
//     - IDLE: in_ready=1. On in_valid&in_ready, register a,b zero-extended to
//       NDIG*DIGIT bits; clear digit counter k=0 and borrow-in; go to CALC.
//     - CALC: in_ready=0. Each cycle computes {bo,d} = a[k] - b[k] - bi.
//       Write d into result slot k; bi<=bo; k<=k+1.
//       After digit NDIG-1 is written, go to DONE.
//     - DONE: out_valid=1, in_ready=0. s = low WIDTH bits of the result
//       register. borrow = bo of the top digit. On out_ready, go to IDLE.
//   - Timing: operands accepted at edge T; out_valid is high after edge T+NDIG.
//     Minimum of NDIG+2 cycles per operation; no back-to-back overlap.
//   - s, borrow and out_valid are held stable while out_valid=1 and out_ready=0.
//     in_valid is ignored outside IDLE, and a/b are don't-care outside IDLE.
//   - Partial top digit (WIDTH % DIGIT != 0): the zero padding keeps the borrow
//     correct. Pad bits of the result are discarded.
//   - NDIG=1: single CALC cycle, identical results.
//   - The digit counter is ceil(log2(NDIG)) bits wide (min 1) and never exceeds
//     NDIG-1.
//   - Parameter check at elaboration: illegal WIDTH/DIGIT prints an ERROR with
//     the value and legal range, then aborts the simulation.
// TESTING (WIDTH=32, DIGIT=8 unless noted)
//   1. a=0x12345678, b=0x02040608
//      -> s=0x10305070, borrow=0; out_valid 4 cycles after accept.
//   2. a=0x00000000, b=0x00000001
//      -> s=0xFFFFFFFF, borrow=1 (borrow ripples through all 4 digits).
//   3. a=0x00000100, b=0x00000001
//      -> s=0x000000FF, borrow=0 (inter-digit borrow).
//   4. Hold out_ready=0 for 5 cycles with in_valid=1 and new a/b
//      -> s/borrow/out_valid stable and in_ready=0; the next op starts only
//         after the result handshake.
//   5. Pulse rst during the 2nd CALC cycle
//      -> out_valid=0, in_ready=1 immediately; the next op a=5, b=3 gives
//         s=2, borrow=0.
//   6. WIDTH=13, DIGIT=4, a=0x0000, b=0x1FFF
//      -> s=0x0001, borrow=1. Then 10k random ops with random in_valid/out_ready
//         gaps: compare against a-b and a<b.

Source files
------------

// File: rtl/au_sub_serial.sv
// au_sub_serial: digit-serial unsigned subtractor, LSD first, valid/ready on both sides
module au_sub_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             borrow,
  output logic             busy
);
  localparam int NDIG = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int PW = NDIG * DIGIT;
  localparam int KW = NDIG > 1 ? $clog2(NDIG) : 1;
  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_param
    $fatal(1, "ERROR: WIDTH=%0d DIGIT=%0d illegal; need WIDTH>=1 and 1<=DIGIT<=WIDTH", WIDTH, DIGIT);
  end
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t         state_q, state_d;
  logic [PW-1:0]  a_q, a_d, b_q, b_d, r_q, r_d;
  logic [KW-1:0]  k_q, k_d;
  logic           bi_q, bi_d;
  logic [DIGIT:0] diff;
  logic [31:0]    off;
  logic           last;
  assign off  = 32'(k_q) * 32'(DIGIT);
  assign diff = {1'b0, a_q[off +: DIGIT]} - {1'b0, b_q[off +: DIGIT]} - (DIGIT+1)'(bi_q);
  assign last = k_q == KW'(NDIG - 1);
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    r_d = r_q;
    k_d = k_q;
    bi_d = bi_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        a_d = PW'(a);
        b_d = PW'(b);
        k_d = '0;
        bi_d = 1'b0;
        state_d = CALC;
      end
      CALC: begin
        r_d[off +: DIGIT] = diff[DIGIT-1:0];
        bi_d = diff[DIGIT];
        k_d = last ? '0 : k_q + 1'b1;
        state_d = last ? DONE : CALC;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      k_q <= '0;
      bi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
      k_q <= k_d;
      bi_q <= bi_d;
    end
  end
  // bi_q holds the top digit's borrow-out once CALC completes
  assign s         = r_q[WIDTH-1:0];
  assign borrow    = bi_q;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
endmodule
